// File: rtl/av_mailbox_slave.sv
// av_mailbox_slave
//
// Avalon-MM responder that lets any interconnect master exchange 16-bit words
// with the synapse316 MCU through two FIFOs (a2m: Avalon to MCU, m2a: MCU to
// Avalon). It also provides a scratch register and status/count registers.
// Flow control is variable-latency waitrequest: a blocked DATA access stalls
// until the FIFO can serve it, or until TIMEOUT stall cycles have elapsed. In
// that case it completes with an error.
//
// Ports:
//   sysclk, sysreset_n     clock (posedge), synchronous active-low reset
//   s_address              word address: 0 DATA, 1 STATUS, 2 SCRATCH, 3 COUNTS
//   s_read, s_write        Avalon strobes (write wins if both are high)
//   s_writedata            Avalon write data
//   s_readdata             read data, valid while s_read=1 and s_waitrequest=0
//   s_waitrequest          stall, low only during the single ACK cycle
//   mcu_data_out           a2m head, 0 when empty
//   mcu_data_read          pops a2m
//   mcu_data_in            m2a push data, also the MCU status write data
//   mcu_data_load          pushes m2a
//   mcu_status_out         {10'b0, mcu_ovf, err, a2m_full, a2m_empty, m2a_full, m2a_empty}
//   mcu_status_load        MCU status write; mcu_data_in[5]=1 clears mcu_ovf
//   irq_a2m_ready          a2m not empty

module av_mailbox_slave #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned TIMEOUT  = 1024,
    parameter logic [15:0] ERR_DATA = 16'hDEAD
) (
    input  logic        sysclk,
    input  logic        sysreset_n,
    input  logic [1:0]  s_address,
    input  logic        s_read,
    input  logic        s_write,
    input  logic [15:0] s_writedata,
    output logic [15:0] s_readdata,
    output logic        s_waitrequest,
    output logic [15:0] mcu_data_out,
    input  logic        mcu_data_read,
    input  logic [15:0] mcu_data_in,
    input  logic        mcu_data_load,
    output logic [15:0] mcu_status_out,
    input  logic        mcu_status_load,
    output logic        irq_a2m_ready
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [TW-1:0] TO_CNT   = TW'(TIMEOUT);

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_SCRATCH = 2'd2;
    localparam logic [1:0] ADDR_COUNTS  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STALL,
        ST_ACK
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] stall_cnt_q, stall_cnt_d;

    // Access being completed, latched when the request is first seen so the
    // ACK-cycle side effects do not depend on the master's ACK-cycle inputs.
    logic          ack_wr_q, ack_wr_d;
    logic [1:0]    ack_addr_q, ack_addr_d;
    logic [15:0]   ack_wdata_q, ack_wdata_d;
    logic          timeout_q, timeout_d;

    logic [15:0]   readdata_q, readdata_d;
    logic [15:0]   scratch_q, scratch_d;
    logic          err_q, err_d;
    logic          mcu_ovf_q, mcu_ovf_d;

    logic [15:0]   a2m_mem_q [DEPTH];
    logic [AW-1:0] a2m_wr_ptr_q, a2m_wr_ptr_d, a2m_rd_ptr_q, a2m_rd_ptr_d;
    logic [CW-1:0] a2m_cnt_q, a2m_cnt_d;

    logic [15:0]   m2a_mem_q [DEPTH];
    logic [AW-1:0] m2a_wr_ptr_q, m2a_wr_ptr_d, m2a_rd_ptr_q, m2a_rd_ptr_d;
    logic [CW-1:0] m2a_cnt_q, m2a_cnt_d;

    logic          a2m_empty, a2m_full, m2a_empty, m2a_full;
    logic          a2m_push, a2m_pop, m2a_push, m2a_pop;
    logic          in_ack, av_data_wr, av_data_rd, ovf_set;
    logic [4:0]    status_bits;
    logic [15:0]   m2a_head_next;
    logic          blocked;

    // ------------------------------------------------------------------
    // FIFO bookkeeping and side effects of the ACK cycle
    // ------------------------------------------------------------------
    // NOTE: every signal gets its default first so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        a2m_empty = (a2m_cnt_q == '0);
        a2m_full  = (a2m_cnt_q == FULL_CNT);
        m2a_empty = (m2a_cnt_q == '0);
        m2a_full  = (m2a_cnt_q == FULL_CNT);

        in_ack     = (state_q == ST_ACK);
        av_data_wr = in_ack && ack_wr_q && (ack_addr_q == ADDR_DATA) && !timeout_q;
        av_data_rd = in_ack && !ack_wr_q && (ack_addr_q == ADDR_DATA) && !timeout_q;

        // A pop in the same cycle frees the slot a push at full needs.
        a2m_pop  = mcu_data_read && !a2m_empty;
        a2m_push = av_data_wr && (!a2m_full || a2m_pop);
        m2a_pop  = av_data_rd && !m2a_empty;
        m2a_push = mcu_data_load && (!m2a_full || m2a_pop);
        ovf_set  = mcu_data_load && !m2a_push;

        a2m_wr_ptr_d = a2m_push ? a2m_wr_ptr_q + AW'(1) : a2m_wr_ptr_q;
        a2m_rd_ptr_d = a2m_pop  ? a2m_rd_ptr_q + AW'(1) : a2m_rd_ptr_q;
        a2m_cnt_d    = a2m_cnt_q + CW'(a2m_push) - CW'(a2m_pop);
        m2a_wr_ptr_d = m2a_push ? m2a_wr_ptr_q + AW'(1) : m2a_wr_ptr_q;
        m2a_rd_ptr_d = m2a_pop  ? m2a_rd_ptr_q + AW'(1) : m2a_rd_ptr_q;
        m2a_cnt_d    = m2a_cnt_q + CW'(m2a_push) - CW'(m2a_pop);

        scratch_d = scratch_q;
        if (in_ack && ack_wr_q && (ack_addr_q == ADDR_SCRATCH)) begin
            scratch_d = ack_wdata_q;
        end

        err_d = err_q;
        if (in_ack && timeout_q) begin
            err_d = 1'b1;
        end else if (in_ack && ack_wr_q && (ack_addr_q == ADDR_STATUS) && ack_wdata_q[4]) begin
            err_d = 1'b0;
        end

        // A new overflow beats a same-cycle clear.
        mcu_ovf_d = mcu_ovf_q;
        if (ovf_set) begin
            mcu_ovf_d = 1'b1;
        end else if (mcu_status_load && mcu_data_in[5]) begin
            mcu_ovf_d = 1'b0;
        end

        status_bits = {err_q, a2m_full, a2m_empty, m2a_full, m2a_empty};

        // Word an m2a pop would return next cycle: if m2a is empty now,
        // the only way it holds data next cycle is this cycle's MCU push.
        m2a_head_next = m2a_empty ? mcu_data_in : m2a_mem_q[m2a_rd_ptr_q];
    end

    // ------------------------------------------------------------------
    // Transaction FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        ack_wr_d    = ack_wr_q;
        ack_addr_d  = ack_addr_q;
        ack_wdata_d = ack_wdata_q;
        timeout_d   = timeout_q;
        readdata_d  = readdata_q;

        // Judged against next cycle's FIFO occupancy, so a pop or push by the
        // MCU in this cycle already unblocks the access for the ACK cycle.
        blocked = (s_address == ADDR_DATA) &&
                  (s_write ? (a2m_cnt_d == FULL_CNT) : (m2a_cnt_d == '0));

        case (state_q)
            ST_IDLE: begin
                if (s_read || s_write) begin
                    ack_wr_d    = s_write;
                    ack_addr_d  = s_address;
                    ack_wdata_d = s_writedata;
                    timeout_d   = 1'b0;
                    stall_cnt_d = '0;
                    state_d     = blocked ? ST_STALL : ST_ACK;
                end
            end
            ST_STALL: begin
                if (!(s_read || s_write)) begin
                    state_d = ST_IDLE;
                end else begin
                    stall_cnt_d = stall_cnt_q + TW'(1);
                    if (!blocked) begin
                        state_d = ST_ACK;
                    end else if (stall_cnt_d == TO_CNT) begin
                        state_d   = ST_ACK;
                        timeout_d = 1'b1;
                    end
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Read data is captured on the transition into ACK.
        if ((state_d == ST_ACK) && (state_q != ST_ACK) && !ack_wr_d) begin
            case (ack_addr_d)
                ADDR_DATA:    readdata_d = timeout_d ? ERR_DATA : m2a_head_next;
                ADDR_STATUS:  readdata_d = {11'b0, status_bits};
                ADDR_SCRATCH: readdata_d = scratch_q;
                default:      readdata_d = {8'(a2m_cnt_q), 8'(m2a_cnt_q)};
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values computed above.
    always_ff @(posedge sysclk) begin
        if (!sysreset_n) begin
            state_q      <= ST_IDLE;
            stall_cnt_q  <= '0;
            ack_wr_q     <= 1'b0;
            ack_addr_q   <= '0;
            ack_wdata_q  <= '0;
            timeout_q    <= 1'b0;
            readdata_q   <= '0;
            scratch_q    <= '0;
            err_q        <= 1'b0;
            mcu_ovf_q    <= 1'b0;
            a2m_wr_ptr_q <= '0;
            a2m_rd_ptr_q <= '0;
            a2m_cnt_q    <= '0;
            m2a_wr_ptr_q <= '0;
            m2a_rd_ptr_q <= '0;
            m2a_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            stall_cnt_q  <= stall_cnt_d;
            ack_wr_q     <= ack_wr_d;
            ack_addr_q   <= ack_addr_d;
            ack_wdata_q  <= ack_wdata_d;
            timeout_q    <= timeout_d;
            readdata_q   <= readdata_d;
            scratch_q    <= scratch_d;
            err_q        <= err_d;
            mcu_ovf_q    <= mcu_ovf_d;
            a2m_wr_ptr_q <= a2m_wr_ptr_d;
            a2m_rd_ptr_q <= a2m_rd_ptr_d;
            a2m_cnt_q    <= a2m_cnt_d;
            m2a_wr_ptr_q <= m2a_wr_ptr_d;
            m2a_rd_ptr_q <= m2a_rd_ptr_d;
            m2a_cnt_q    <= m2a_cnt_d;
        end
    end

    // NOTE: FIFO storage is not reset; the counts define which entries are
    // valid, so stale contents are never observed.
    always_ff @(posedge sysclk) begin
        if (a2m_push) begin
            a2m_mem_q[a2m_wr_ptr_q] <= ack_wdata_q;
        end
        if (m2a_push) begin
            m2a_mem_q[m2a_wr_ptr_q] <= mcu_data_in;
        end
    end

    assign s_waitrequest  = (state_q != ST_ACK);
    assign s_readdata     = readdata_q;
    assign mcu_data_out   = a2m_empty ? 16'h0000 : a2m_mem_q[a2m_rd_ptr_q];
    assign mcu_status_out = {10'b0, mcu_ovf_q, status_bits};
    assign irq_a2m_ready  = !a2m_empty;

endmodule

// File: tb/tb_av_mailbox_slave.sv
// tb_av_mailbox_slave
//
// Directed bench for av_mailbox_slave (DEPTH=16, TIMEOUT=8). A queue-based
// model of the two mailboxes, err, mcu_ovf and scratch is compared against
// the DUT outputs on every falling edge. Directed tasks pin waitrequest
// latency, read data and status words to hand-computed literals.

module tb_av_mailbox_slave;

    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 8;
    localparam logic [15:0] ERR_DATA = 16'hDEAD;

    logic        sysclk;
    logic        sysreset_n;
    logic [1:0]  s_address;
    logic        s_read;
    logic        s_write;
    logic [15:0] s_writedata;
    logic [15:0] s_readdata;
    logic        s_waitrequest;
    logic [15:0] mcu_data_out;
    logic        mcu_data_read;
    logic [15:0] mcu_data_in;
    logic        mcu_data_load;
    logic [15:0] mcu_status_out;
    logic        mcu_status_load;
    logic        irq_a2m_ready;

    int total = 0;
    int bad   = 0;

    // Model state
    logic [15:0] a2m_m[$];
    logic [15:0] m2a_m[$];
    logic        m_err     = 1'b0;
    logic        m_ovf     = 1'b0;
    logic [15:0] m_scratch = 16'h0;

    av_mailbox_slave #(
        .DEPTH    (DEPTH),
        .TIMEOUT  (TIMEOUT),
        .ERR_DATA (ERR_DATA)
    ) dut (
        .sysclk          (sysclk),
        .sysreset_n      (sysreset_n),
        .s_address       (s_address),
        .s_read          (s_read),
        .s_write         (s_write),
        .s_writedata     (s_writedata),
        .s_readdata      (s_readdata),
        .s_waitrequest   (s_waitrequest),
        .mcu_data_out    (mcu_data_out),
        .mcu_data_read   (mcu_data_read),
        .mcu_data_in     (mcu_data_in),
        .mcu_data_load   (mcu_data_load),
        .mcu_status_out  (mcu_status_out),
        .mcu_status_load (mcu_status_load),
        .irq_a2m_ready   (irq_a2m_ready)
    );

    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] model_flags(input int a_n, input int m_n, input logic e);
        return {e, a_n == DEPTH, a_n == 0, m_n == DEPTH, m_n == 0};
    endfunction

    // Compare, then advance the model by what the coming edge must do.
    always @(negedge sysclk) begin : model_proc
        int          a2m_n;
        int          m2a_n;
        logic        av_ack;
        logic        av_m2a_pop;
        logic        new_ovf;
        logic [15:0] exp_rd;

        a2m_n = a2m_m.size();
        m2a_n = m2a_m.size();
        av_ack = (s_read || s_write) && !s_waitrequest;

        check("mcu_data_out", mcu_data_out, (a2m_n > 0) ? a2m_m[0] : 16'h0000);
        check("irq_a2m_ready", irq_a2m_ready, a2m_n > 0);
        check("mcu_status_out", mcu_status_out, {10'b0, m_ovf, model_flags(a2m_n, m2a_n, m_err)});
        if (!s_read && !s_write) begin
            check("waitrequest_idle", s_waitrequest, 1'b1);
        end
        if (av_ack && s_read && !s_write) begin
            case (s_address)
                2'd0:    exp_rd = (m2a_n > 0) ? m2a_m[0] : ERR_DATA;
                2'd1:    exp_rd = {11'b0, model_flags(a2m_n, m2a_n, m_err)};
                2'd2:    exp_rd = m_scratch;
                default: exp_rd = {8'(a2m_n), 8'(m2a_n)};
            endcase
            check("readdata_model", s_readdata, exp_rd);
        end

        if (!sysreset_n) begin
            a2m_m.delete();
            m2a_m.delete();
            m_err     = 1'b0;
            m_ovf     = 1'b0;
            m_scratch = 16'h0;
        end else begin
            av_m2a_pop = 1'b0;
            new_ovf    = 1'b0;
            if (mcu_data_read && a2m_n > 0) begin
                void'(a2m_m.pop_front());
            end
            if (av_ack) begin
                if (s_write) begin
                    case (s_address)
                        2'd0: begin
                            if (a2m_n < DEPTH) a2m_m.push_back(s_writedata);
                            else m_err = 1'b1;
                        end
                        2'd1: if (s_writedata[4]) m_err = 1'b0;
                        2'd2: m_scratch = s_writedata;
                        default: ;
                    endcase
                end else if (s_address == 2'd0) begin
                    if (m2a_n > 0) begin
                        void'(m2a_m.pop_front());
                        av_m2a_pop = 1'b1;
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end
            if (mcu_data_load) begin
                if (m2a_n < DEPTH || av_m2a_pop) m2a_m.push_back(mcu_data_in);
                else new_ovf = 1'b1;
            end
            if (new_ovf) m_ovf = 1'b1;
            else if (mcu_status_load && mcu_data_in[5]) m_ovf = 1'b0;
        end
    end

    // One Avalon access; exp_wait is the number of cycles waitrequest stays
    // high, counting the cycle in which the request is first presented.
    task automatic av_xfer(input logic wr, input logic [1:0] addr, input logic [15:0] wd,
                           input int exp_wait, input logic [15:0] exp_rd, input string name);
        int waits = 0;
        bit done  = 1'b0;
        @(posedge sysclk); #1;
        s_address   = addr;
        s_writedata = wd;
        s_write     = wr;
        s_read      = !wr;
        while (!done) begin
            @(negedge sysclk);
            if (!s_waitrequest) done = 1'b1;
            else begin
                waits++;
                if (waits > TIMEOUT + 8) done = 1'b1;
            end
        end
        check({name, " wait"}, waits, exp_wait);
        if (!wr) check({name, " rdata"}, s_readdata, exp_rd);
        @(posedge sysclk); #1;
        s_read  = 1'b0;
        s_write = 1'b0;
    endtask

    task automatic mcu_pop(input logic [15:0] exp);
        @(posedge sysclk); #1;
        check("mcu_pop data", mcu_data_out, exp);
        mcu_data_read = 1'b1;
        @(posedge sysclk); #1;
        mcu_data_read = 1'b0;
    endtask

    task automatic mcu_push(input logic [15:0] v);
        @(posedge sysclk); #1;
        mcu_data_in   = v;
        mcu_data_load = 1'b1;
        @(posedge sysclk); #1;
        mcu_data_load = 1'b0;
    endtask

    initial begin
        sysreset_n      = 1'b0;
        s_address       = 2'd0;
        s_read          = 1'b0;
        s_write         = 1'b0;
        s_writedata     = 16'h0;
        mcu_data_read   = 1'b0;
        mcu_data_in     = 16'h0;
        mcu_data_load   = 1'b0;
        mcu_status_load = 1'b0;
        repeat (3) @(posedge sysclk);
        #1;
        check("rst waitrequest", s_waitrequest, 1'b1);
        check("rst readdata", s_readdata, 16'h0000);
        check("rst mcu_status", mcu_status_out, 16'h0005);
        check("rst irq", irq_a2m_ready, 1'b0);
        check("rst mcu_data_out", mcu_data_out, 16'h0000);
        sysreset_n = 1'b1;

        // Scratch round trip, one wait cycle each.
        av_xfer(1'b1, 2'd2, 16'h1234, 1, 16'h0, "scratch_wr");
        av_xfer(1'b0, 2'd2, 16'h0, 1, 16'h1234, "scratch_rd");

        // Fill a2m with 1..16.
        for (int i = 1; i <= DEPTH; i++) begin
            av_xfer(1'b1, 2'd0, 16'(i), 1, 16'h0, "a2m_wr");
            if (i == 1) check("irq after first write", irq_a2m_ready, 1'b1);
        end
        check("a2m_full status bit", mcu_status_out[3], 1'b1);
        av_xfer(1'b0, 2'd3, 16'h0, 1, 16'h1000, "counts_a2m_full");

        // 17th write stalls; MCU pop in stall cycle 5 releases it.
        fork
            av_xfer(1'b1, 2'd0, 16'd17, 6, 16'h0, "a2m_wr_stall");
            begin
                repeat (6) @(posedge sysclk);
                #1;
                check("pop during stall", mcu_data_out, 16'd1);
                mcu_data_read = 1'b1;
                @(posedge sysclk); #1;
                mcu_data_read = 1'b0;
            end
        join
        for (int i = 2; i <= 17; i++) mcu_pop(16'(i));
        check("status after drain", mcu_status_out, 16'h0005);

        // Read of empty m2a times out after TIMEOUT stall cycles.
        av_xfer(1'b0, 2'd0, 16'h0, TIMEOUT + 1, 16'hDEAD, "rd_timeout");
        av_xfer(1'b0, 2'd1, 16'h0, 1, 16'h0015, "status_err");
        av_xfer(1'b1, 2'd1, 16'h0010, 1, 16'h0, "status_clr");
        av_xfer(1'b0, 2'd1, 16'h0, 1, 16'h0005, "status_clean");

        // MCU fills m2a, then overflows it.
        for (int i = 1; i <= DEPTH; i++) mcu_push(16'hA000 + 16'(i));
        check("m2a full status", mcu_status_out, 16'h0006);
        mcu_push(16'hA011);
        check("m2a overflow status", mcu_status_out, 16'h0026);
        // Clear request coinciding with a new overflow: overflow wins.
        @(posedge sysclk); #1;
        mcu_data_in     = 16'h0020;
        mcu_data_load   = 1'b1;
        mcu_status_load = 1'b1;
        @(posedge sysclk); #1;
        mcu_data_load   = 1'b0;
        mcu_status_load = 1'b0;
        check("ovf clear vs new ovf", mcu_status_out, 16'h0026);
        @(posedge sysclk); #1;
        mcu_status_load = 1'b1;
        @(posedge sysclk); #1;
        mcu_status_load = 1'b0;
        check("ovf cleared", mcu_status_out, 16'h0006);
        av_xfer(1'b0, 2'd3, 16'h0, 1, 16'h0010, "counts_m2a_full");

        // MCU push at full in the same cycle as the Avalon pop is accepted.
        fork
            av_xfer(1'b0, 2'd0, 16'h0, 1, 16'hA001, "rd_full_push");
            begin
                repeat (2) @(posedge sysclk);
                #1;
                mcu_data_in   = 16'hA0FF;
                mcu_data_load = 1'b1;
                @(posedge sysclk); #1;
                mcu_data_load = 1'b0;
            end
        join
        check("status after push+pop", mcu_status_out, 16'h0006);
        for (int i = 2; i <= DEPTH; i++) av_xfer(1'b0, 2'd0, 16'h0, 1, 16'hA000 + 16'(i), "m2a_rd");
        av_xfer(1'b0, 2'd0, 16'h0, 1, 16'hA0FF, "m2a_rd_last");
        check("status m2a drained", mcu_status_out, 16'h0005);

        // Reset while a DATA read is stalled.
        av_xfer(1'b1, 2'd0, 16'h5555, 1, 16'h0, "a2m_wr_pre_rst");
        @(posedge sysclk); #1;
        s_address = 2'd0;
        s_read    = 1'b1;
        repeat (3) @(posedge sysclk);
        #1;
        check("stalled before reset", s_waitrequest, 1'b1);
        sysreset_n = 1'b0;
        s_read     = 1'b0;
        @(posedge sysclk); #1;
        check("post-rst waitrequest", s_waitrequest, 1'b1);
        check("post-rst irq", irq_a2m_ready, 1'b0);
        check("post-rst mcu_status", mcu_status_out, 16'h0005);
        check("post-rst mcu_data_out", mcu_data_out, 16'h0000);
        check("post-rst readdata", s_readdata, 16'h0000);
        sysreset_n = 1'b1;
        av_xfer(1'b0, 2'd3, 16'h0, 1, 16'h0000, "post-rst counts");
        av_xfer(1'b0, 2'd2, 16'h0, 1, 16'h0000, "post-rst scratch");

        repeat (2) @(posedge sysclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
